// File: rtl/apb_slave_regfile.sv
// APB completer serving a bank of 32-bit registers.
// Register 0 is a read-only ID word; the others are read/write with byte strobes.
// The access phase is stretched by a fixed number of wait states. Illegal
// transfers complete with pslverr and leave the registers untouched.
module apb_slave_regfile #(
    parameter int unsigned                ADDRESS_WIDTH = 32,
    parameter int unsigned                DATA_WIDTH    = 32,
    parameter int unsigned                NUM_REGS      = 16,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = '0,
    parameter int unsigned                WAIT_STATES   = 0,
    parameter logic [DATA_WIDTH-1:0]      ID_VALUE      = 32'hA5B0_0001
) (
    input  logic                           pclk,
    input  logic                           preset_n,
    input  logic                           psel,
    input  logic                           penable,
    input  logic [ADDRESS_WIDTH-1:0]       paddr,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [2:0]                     pprot,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int unsigned IDX_W     = $clog2(NUM_REGS);
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    // Byte-offset bits inside the register window; BASE_ADDR has them all zero.
    localparam logic [ADDRESS_WIDTH-1:0] SPAN_MASK = ADDRESS_WIDTH'(NUM_REGS * 4 - 1);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    // The setup phase has no state of its own. It is recognised on the edge
    // that ends it, so that pready can be registered high for the first
    // access cycle when there are no wait states.
    typedef enum logic {StIdle, StAccess} state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic                   write_q;
    logic [NUM_BYTES-1:0]   strb_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   err_q;
    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];

    logic                   setup_seen;
    logic                   in_range;
    logic                   misaligned;
    logic [IDX_W-1:0]       setup_idx;
    logic                   setup_err;
    logic [DATA_WIDTH-1:0]  setup_rdata;
    logic [DATA_WIDTH-1:0]  lat_rdata;
    logic                   completing;

    // pprot[2:1] carry no meaning for this register bank.
    logic unused_prot;
    assign unused_prot = ^pprot[2:1];

    // Decode the setup-phase inputs and form the registered read data.
    always_comb begin
        setup_seen = (state_q == StIdle) && psel && !penable;
        in_range   = (paddr & ~SPAN_MASK) == BASE_ADDR;
        misaligned = paddr[1:0] != 2'b00;
        setup_idx  = paddr[IDX_W+1:2];
        setup_err  = !in_range || misaligned ||
                     (pwrite && ((setup_idx == '0) || !pprot[0]));
        setup_rdata = '0;
        if (!setup_err && !pwrite) begin
            setup_rdata = (setup_idx == '0) ? ID_VALUE : regs_q[setup_idx];
        end
        lat_rdata = '0;
        if (!err_q && !write_q) begin
            lat_rdata = (idx_q == '0) ? ID_VALUE : regs_q[idx_q];
        end
        completing = (state_q == StAccess) && psel && penable && pready;
    end

    // Transfer FSM: latch the request, count wait states, drive the response.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (setup_seen) begin
                        write_q <= pwrite;
                        strb_q  <= pstrb;
                        wdata_q <= pwdata;
                        idx_q   <= setup_idx;
                        err_q   <= setup_err;
                        cnt_q   <= WAIT_INIT;
                        state_q <= StAccess;
                        if (WAIT_INIT == 4'd0) begin
                            pready  <= 1'b1;
                            pslverr <= setup_err;
                            prdata  <= setup_rdata;
                        end
                    end
                end
                StAccess: begin
                    if (!psel) begin
                        // Master abandoned the transfer.
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                    end else if (pready) begin
                        if (penable) begin
                            state_q <= StIdle;
                            pready  <= 1'b0;
                            pslverr <= 1'b0;
                            prdata  <= '0;
                        end
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            pready  <= 1'b1;
                            pslverr <= err_q;
                            prdata  <= lat_rdata;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Register bank: byte-lane write on a clean write completion.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (completing && write_q && !err_q) begin
            for (int k = 0; k < int'(NUM_BYTES); k++) begin
                if (strb_q[k]) begin
                    regs_q[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
        assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: one zero-wait instance and one three-wait-state instance.
module tb_apb_slave_regfile;

    logic         pclk = 1'b0;
    logic         preset_n = 1'b0;
    logic         psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0]  paddr = '0, pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic [2:0]   pprot = '0;
    logic         pready0, pslverr0, pready3, pslverr3;
    logic [31:0]  prdata0, prdata3;
    logic [511:0] regs0, regs3;

    int total = 0;
    int bad = 0;

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.WAIT_STATES(0)) dut0 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel0), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
        .pprot(pprot), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0),
        .regs_o(regs0)
    );

    apb_slave_regfile #(.WAIT_STATES(3)) dut3 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel3), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
        .pprot(pprot), .pready(pready3), .prdata(prdata3), .pslverr(pslverr3),
        .regs_o(regs3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Full transfer; returns at the negedge of the completion cycle.
    task automatic xfer(input bit sel3, input logic [31:0] addr, input bit wr,
                        input logic [3:0] strb, input logic [31:0] data,
                        input logic [2:0] prot, output logic [31:0] rd,
                        output logic err, output int waits);
        @(negedge pclk);
        psel0 = !sel3; psel3 = sel3; penable = 1'b0;
        paddr = addr; pwrite = wr; pstrb = strb; pwdata = data; pprot = prot;
        @(negedge pclk);
        penable = 1'b1;
        waits = 0;
        while (!(sel3 ? pready3 : pready0) && waits < 20) begin
            waits++;
            @(negedge pclk);
        end
        rd  = sel3 ? prdata3 : prdata0;
        err = sel3 ? pslverr3 : pslverr0;
        if (waits >= 20) chk("pready_timeout", 32'(waits), 32'd0);
    endtask

    task automatic bus_idle();
        @(negedge pclk);
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          w;

    initial begin
        #12;
        chk("rst_pready", 32'(pready0), 32'd0);
        chk("rst_prdata", prdata0, 32'd0);
        chk("rst_pslverr", 32'(pslverr0), 32'd0);
        chk("rst_regs", 32'(|regs0), 32'd0);
        @(negedge pclk);
        preset_n = 1'b1;

        // ID register, zero wait states
        xfer(0, 32'h0, 0, 4'h0, 32'h0, 3'b000, rd, err, w);
        chk("id_data", rd, 32'hA5B0_0001);
        chk("id_err", 32'(err), 32'd0);
        chk("id_waits", 32'(w), 32'd0);
        bus_idle();
        chk("post_pready", 32'(pready0), 32'd0);
        chk("post_prdata", prdata0, 32'd0);

        // Full write then read back
        xfer(0, 32'h8, 1, 4'hF, 32'hDEAD_BEEF, 3'b001, rd, err, w);
        chk("wr8_err", 32'(err), 32'd0);
        bus_idle();
        xfer(0, 32'h8, 0, 4'h0, 32'h0, 3'b000, rd, err, w);
        chk("rd8_data", rd, 32'hDEAD_BEEF);
        chk("rd8_regs", regs0[95:64], 32'hDEAD_BEEF);
        bus_idle();

        // Partial strobe write
        xfer(0, 32'h8, 1, 4'b0101, 32'h1122_3344, 3'b001, rd, err, w);
        bus_idle();
        xfer(0, 32'h8, 0, 4'hF, 32'h0, 3'b000, rd, err, w);
        chk("strb_data", rd, 32'hDE22_BE44);
        bus_idle();

        // Error cases
        xfer(0, 32'h0, 1, 4'hF, 32'h1234_5678, 3'b001, rd, err, w);
        chk("wr0_err", 32'(err), 32'd1);
        bus_idle();
        chk("wr0_regs", regs0[31:0], 32'h0);
        chk("wr0_pslverr_clr", 32'(pslverr0), 32'd0);
        xfer(0, 32'h40, 0, 4'h0, 32'h0, 3'b000, rd, err, w);
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_data", rd, 32'h0);
        bus_idle();
        xfer(0, 32'h6, 1, 4'hF, 32'hFFFF_FFFF, 3'b001, rd, err, w);
        chk("mis_err", 32'(err), 32'd1);
        bus_idle();
        chk("mis_reg1", regs0[63:32], 32'h0);
        xfer(0, 32'hC, 1, 4'hF, 32'hCAFE_F00D, 3'b000, rd, err, w);
        chk("prot_err", 32'(err), 32'd1);
        bus_idle();
        chk("prot_reg3", regs0[127:96], 32'h0);
        xfer(0, 32'hC, 0, 4'h0, 32'h0, 3'b000, rd, err, w);
        chk("unpriv_rd_err", 32'(err), 32'd0);
        bus_idle();

        // Zero strobe is a legal no-op
        xfer(0, 32'h8, 1, 4'h0, 32'h0, 3'b001, rd, err, w);
        chk("nostrb_err", 32'(err), 32'd0);
        bus_idle();
        chk("nostrb_reg2", regs0[95:64], 32'hDE22_BE44);

        // Wait states, then back-to-back read with no idle cycle
        xfer(1, 32'h4, 1, 4'hF, 32'h1234_5678, 3'b001, rd, err, w);
        chk("ws_wr_waits", 32'(w), 32'd3);
        chk("ws_wr_err", 32'(err), 32'd0);
        xfer(1, 32'h4, 0, 4'h0, 32'h0, 3'b000, rd, err, w);
        chk("ws_rd_waits", 32'(w), 32'd3);
        chk("ws_rd_data", rd, 32'h1234_5678);
        bus_idle();

        // psel dropped mid-wait
        @(negedge pclk);
        psel3 = 1'b1; penable = 1'b0; paddr = 32'hC; pwrite = 1'b1;
        pstrb = 4'hF; pwdata = 32'h5555_AAAA; pprot = 3'b001;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel3 = 1'b0; penable = 1'b0;
        repeat (5) @(negedge pclk);
        chk("abort_pready", 32'(pready3), 32'd0);
        chk("abort_reg3", regs3[127:96], 32'h0);

        // Reset mid-access
        @(negedge pclk);
        psel3 = 1'b1; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        preset_n = 1'b0;
        #1;
        chk("rstmid_pready", 32'(pready3), 32'd0);
        chk("rstmid_prdata", prdata3, 32'h0);
        chk("rstmid_pslverr", 32'(pslverr3), 32'd0);
        chk("rstmid_regs", 32'(|regs3), 32'd0);
        psel3 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        repeat (5) @(negedge pclk);
        chk("rstmid_reg3", regs3[127:96], 32'h0);
        chk("rstmid_after_pready", 32'(pready3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
